// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change payout path.
package vm_pkg;
  typedef enum logic [1:0] {IDLE, PLAN, COIN, GAP} state_e;
  typedef enum logic {DIME, NICKEL} coin_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INSUF   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Coin values in nickel units
  localparam int COIN_VALUE_DIME   = 2;
  localparam int COIN_VALUE_NICKEL = 1;
endpackage

// File: rtl/vm_coin_counter.sv
// Saturating up/down inventory counter; simultaneous inc and dec cancel out.
module vm_coin_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 cnt_q <= INIT;
    else if (inc && !dec && (cnt_q != '1))    cnt_q <= cnt_q + WIDTH'(1);
    else if (dec && !inc && (cnt_q != '0))    cnt_q <= cnt_q - WIDTH'(1);
  end

  assign count = cnt_q;
endmodule

// File: rtl/vm_change_dispenser.sv
// Change payout: greedy dime-first planning, one-coin-at-a-time eject with ack
// handshake and timeout, and dime/nickel inventory tracking.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W        = 5,
  parameter int CNT_W        = 8,
  parameter int ACK_TIMEOUT  = 15,
  parameter int INIT_DIMES   = 0,
  parameter int INIT_NICKELS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill_d,
  input  logic             refill_n,
  output logic             dime_out,
  output logic             nickel_out,
  input  logic             mech_ack,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] nickel_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = CNT_W + AMT_W + 1;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W:0]   nd_q, nd_d, nn_q, nn_d;
  logic [TW-1:0]    to_q, to_d;
  logic             done_q, done_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             dec_dime, dec_nick;
  coin_e            cur_coin;
  logic [PW-1:0]    half, dcnt, plan_nd, plan_nn;

  vm_coin_counter #(.WIDTH(CNT_W), .INIT(CNT_W'(INIT_DIMES))) u_dimes (
    .clk(clk), .rst(rst), .inc(refill_d), .dec(dec_dime), .count(dime_cnt));

  vm_coin_counter #(.WIDTH(CNT_W), .INIT(CNT_W'(INIT_NICKELS))) u_nickels (
    .clk(clk), .rst(rst), .inc(refill_n), .dec(dec_nick), .count(nickel_cnt));

  // Planner works in a width that holds both the amount and the inventory
  assign half     = PW'(amt_q >> 1);
  assign dcnt     = PW'(dime_cnt);
  assign plan_nd  = (dcnt < half) ? dcnt : half;
  assign plan_nn  = PW'(amt_q) - PW'(COIN_VALUE_DIME) * plan_nd;
  assign cur_coin = (nd_q != '0) ? DIME : NICKEL;

  always_comb begin
    state_d  = state_q;
    amt_d    = amt_q;
    nd_d     = nd_q;
    nn_d     = nn_q;
    to_d     = to_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    dec_dime = 1'b0;
    dec_nick = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        amt_d = req_amount;
        if (req_amount == '0) done_d  = 1'b1;
        else                  state_d = PLAN;
      end
      PLAN: if (plan_nn > PW'(nickel_cnt)) begin
        err_d   = 1'b1;
        code_d  = ERR_INSUF;
        state_d = IDLE;
      end else begin
        nd_d    = (AMT_W+1)'(plan_nd);
        nn_d    = (AMT_W+1)'(plan_nn);
        to_d    = '0;
        state_d = COIN;
      end
      COIN: if (mech_ack) begin
        if (cur_coin == DIME) begin
          nd_d     = nd_q - (AMT_W+1)'(1);
          dec_dime = 1'b1;
        end else begin
          nn_d     = nn_q - (AMT_W+1)'(1);
          dec_nick = 1'b1;
        end
        state_d = GAP;
      end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = IDLE;
      end else begin
        to_d = to_q + TW'(1);
      end
      GAP: if ((nd_q | nn_q) != '0) begin
        to_d    = '0;
        state_d = COIN;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      amt_q   <= '0;
      nd_q    <= '0;
      nn_q    <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      amt_q   <= amt_d;
      nd_q    <= nd_d;
      nn_q    <= nn_d;
      to_q    <= to_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign dime_out   = (state_q == COIN) && (cur_coin == DIME);
  assign nickel_out = (state_q == COIN) && (cur_coin == NICKEL);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: vector table plus corner sequences.
module tb_vm_change_dispenser;
  localparam int AMT_W = 5;
  localparam int CNT_W = 8;
  localparam int TO    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, refill_d, refill_n, mech_ack;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready, dime_out, nickel_out, done, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] dime_cnt, nickel_cnt;

  vm_change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .ACK_TIMEOUT(TO),
                        .INIT_DIMES(0), .INIT_NICKELS(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .refill_d(refill_d), .refill_n(refill_n),
    .dime_out(dime_out), .nickel_out(nickel_out), .mech_ack(mech_ack),
    .done(done), .err(err), .err_code(err_code),
    .dime_cnt(dime_cnt), .nickel_cnt(nickel_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int    dimes;
    int    nickels;
    int    amt;
    string seq;
    int    exp_done;
    int    exp_code;
    int    exp_d;
    int    exp_n;
  } vec_t;

  vec_t vt[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; req_amount = '0;
    refill_d = 1'b0; refill_n = 1'b0; mech_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic refill(input int d, input int n);
    int m;
    m = (d > n) ? d : n;
    for (int i = 0; i < m; i++) begin
      refill_d = (i < d);
      refill_n = (i < n);
      @(negedge clk);
    end
    refill_d = 1'b0;
    refill_n = 1'b0;
  endtask

  // Mechanism acks each coin 2 cycles after its line rises.
  task automatic run_vec(input vec_t v, input int idx);
    string seq;
    int cyc, first, end_cyc, age, low, gap_bad, both, exp_end;
    logic prev, line, g_done, g_err;
    logic [1:0] g_code;
    do_reset();
    refill(v.dimes, v.nickels);
    req_valid = 1'b1; req_amount = AMT_W'(v.amt);
    @(negedge clk);
    req_valid = 1'b0;
    seq = ""; cyc = 1; first = -1; end_cyc = -1; age = 0; low = 0;
    gap_bad = 0; both = 0; prev = 1'b0; g_done = 1'b0; g_err = 1'b0; g_code = 2'b00;
    while (cyc < 200 && end_cyc < 0) begin
      line = dime_out | nickel_out;
      if (dime_out && nickel_out) both++;
      if ((line || done || err) && first < 0) first = cyc;
      if (line) begin
        if (!prev) begin
          age = 0;
          seq = {seq, dime_out ? "D" : "N"};
          if (seq.len() > 1 && low != 1) gap_bad++;
        end else age++;
        low = 0;
      end else low++;
      prev = line;
      mech_ack = line && (age == 2);
      if (done || err) begin
        end_cyc = cyc; g_done = done; g_err = err; g_code = err_code;
      end
      @(negedge clk);
      cyc++;
    end
    mech_ack = 1'b0;
    chk($sformatf("v%0d_finished", idx), end_cyc >= 0, 1);
    checks++;
    if (seq != v.seq) begin
      errors++;
      $display("FAIL v%0d_seq: got '%s' expected '%s'", idx, seq, v.seq);
    end
    exp_end = (v.amt == 0) ? 1 : ((v.exp_done != 0) ? 2 + 4 * v.seq.len() : 2);
    chk($sformatf("v%0d_first_cyc", idx), first, (v.amt == 0) ? 1 : 2);
    chk($sformatf("v%0d_end_cyc", idx), end_cyc, exp_end);
    chk($sformatf("v%0d_done", idx), g_done, v.exp_done);
    chk($sformatf("v%0d_err", idx), g_err, (v.exp_done != 0) ? 0 : 1);
    chk($sformatf("v%0d_code", idx), g_code, v.exp_code);
    chk($sformatf("v%0d_gap", idx), gap_bad, 0);
    chk($sformatf("v%0d_both_lines", idx), both, 0);
    chk($sformatf("v%0d_pulse_len", idx), done | err, 0);
    chk($sformatf("v%0d_ready", idx), req_ready, 1);
    chk($sformatf("v%0d_dime_cnt", idx), dime_cnt, v.exp_d);
    chk($sformatf("v%0d_nickel_cnt", idx), nickel_cnt, v.exp_n);
  endtask

  initial begin
    int nhigh, dage, got, act;
    rst = 1'b0; req_valid = 1'b0; req_amount = '0;
    refill_d = 1'b0; refill_n = 1'b0; mech_ack = 1'b0;

    vt[0] = '{3, 2, 5, "DDN", 1, 0, 1, 1};
    vt[1] = '{0, 2, 3, "", 0, 1, 0, 2};
    vt[2] = '{1, 5, 4, "DNN", 1, 0, 0, 3};
    vt[3] = '{0, 0, 0, "", 1, 0, 0, 0};
    vt[4] = '{10, 0, 7, "", 0, 1, 10, 0};
    vt[5] = '{2, 10, 31, "", 0, 1, 2, 10};
    vt[6] = '{20, 1, 31, "DDDDDDDDDDDDDDDN", 1, 0, 5, 0};
    vt[7] = '{0, 3, 3, "NNN", 1, 0, 0, 0};

    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_lines", {dime_out, nickel_out}, 0);
    chk("rst_pulses", {done, err, err_code}, 0);
    chk("rst_counts", {dime_cnt, nickel_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted mid-COIN clears everything immediately
    refill(2, 0);
    req_valid = 1'b1; req_amount = 5'd2;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("a_line_before_rst", dime_out, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("a_rst_lines", {dime_out, nickel_out}, 0);
    chk("a_rst_pulses", {done, err, err_code}, 0);
    chk("a_rst_counts", {dime_cnt, nickel_cnt}, 0);
    chk("a_rst_ready", req_ready, 1);
    @(negedge clk); rst = 1'b1;
    refill(3, 2);
    chk("a_refill_dime", dime_cnt, 3);
    chk("a_refill_nickel", nickel_cnt, 2);

    foreach (vt[i]) run_vec(vt[i], i);

    // Timeout after one acked dime: nickel line held exactly TO cycles
    do_reset();
    refill(1, 1);
    req_valid = 1'b1; req_amount = 5'd3;
    @(negedge clk); req_valid = 1'b0;
    nhigh = 0; dage = 0; got = 0;
    for (int c = 0; c < 100; c++) begin
      if (err) begin got = 1; break; end
      if (dime_out) dage++;
      mech_ack = dime_out && (dage == 3);
      if (nickel_out) nhigh++;
      @(negedge clk);
    end
    mech_ack = 1'b0;
    chk("b_err_seen", got, 1);
    chk("b_nickel_high_cycles", nhigh, TO);
    chk("b_err_code", err_code, 2);
    chk("b_ready", req_ready, 1);
    chk("b_line_dropped", nickel_out, 0);
    chk("b_dime_deducted", dime_cnt, 0);
    chk("b_nickel_kept", nickel_cnt, 1);
    @(negedge clk);
    chk("b_err_pulse_len", err, 0);

    // Refill coinciding with dime ack, and req_valid ignored during COIN
    do_reset();
    refill(2, 0);
    req_valid = 1'b1; req_amount = 5'd4;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("c_dime_line", dime_out, 1);
    chk("c_ready_low", req_ready, 0);
    req_valid = 1'b1; req_amount = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    mech_ack = 1'b1; refill_d = 1'b1;
    @(negedge clk);
    mech_ack = 1'b0; refill_d = 1'b0;
    chk("c_cnt_net_zero", dime_cnt, 2);
    chk("c_gap_low", dime_out | nickel_out, 0);
    @(negedge clk);
    chk("c_second_dime", dime_out, 1);
    mech_ack = 1'b1;
    @(negedge clk);
    mech_ack = 1'b0;
    chk("c_cnt_after_2nd", dime_cnt, 1);
    @(negedge clk);
    chk("c_done", done, 1);
    act = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || err || dime_out || nickel_out) act++;
    end
    chk("c_no_queued_req", act, 0);
    mech_ack = 1'b1;
    @(negedge clk);
    mech_ack = 1'b0;
    @(negedge clk);
    chk("c_idle_ack_ignored", dime_cnt, 1);

    // Inventory saturates at the top
    do_reset();
    refill(300, 260);
    chk("d_dime_sat", dime_cnt, 255);
    chk("d_nickel_sat", nickel_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
